ram_bus_master: RTL

- Initiator side of the single-port lpm_ram interface. It drives addr/wren/data into the RAM and samples q.
- Upstream logic (CPU control unit, loader, test harness) issues one-word READ/WRITE commands and multi-word FILL/SUM commands through a valid/ready handshake.
- The master sequences RAM cycles, respects RAM read latency, and returns one response per accepted command.

---
 rtl/ram_bus_master.sv | 110 +++++++++++
 1 files changed

// File: rtl/ram_bus_master.sv
// ram_bus_master: sequences single-port RAM cycles for READ/WRITE/FILL/SUM commands and returns one response each.
//   sys_clk/aclr          : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake; cmd_op 00 READ, 01 WRITE, 10 FILL, 11 SUM
//   cmd_addr/len/data     : start address, word count minus 1, write/fill value
//   rsp_valid/rsp_data    : one-cycle response pulse and its data (held until next response)
//   busy                  : inverse of cmd_ready
//   ram_addr/wren/data/q  : lpm_ram port
module ram_bus_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                sys_clk,
  input  logic                aclr,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [ADDR_W-1:0]   cmd_len,
  input  logic [DATA_W-1:0]   cmd_data,
  output logic                rsp_valid,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                busy,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_wren,
  output logic [DATA_W-1:0]   ram_data,
  input  logic [DATA_W-1:0]   ram_q
);
  localparam int WW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_WAIT, RESP} state_t;
  state_t              r_state;
  logic [ADDR_W-1:0]   r_rem;
  logic [2*DATA_W-1:0] r_acc;
  logic [WW-1:0]       r_wait;
  logic                r_rsp_valid;
  logic [2*DATA_W-1:0] r_rsp_data;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_ram_wren;
  logic [DATA_W-1:0]   r_ram_data;
  logic [2*DATA_W-1:0] w_sum;
  logic                w_is_wr;
  // READ starts with acc=0, so acc+q is exactly the zero-extended word
  assign w_sum     = r_acc + {{DATA_W{1'b0}}, ram_q};
  assign w_is_wr   = ^cmd_op;
  assign cmd_ready = r_state == IDLE;
  assign busy      = !cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign ram_addr  = r_ram_addr;
  assign ram_wren  = r_ram_wren;
  assign ram_data  = r_ram_data;
  always_ff @(posedge sys_clk or posedge aclr) begin
    if (aclr) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_acc       <= '0;
      r_wait      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_ram_addr  <= '0;
      r_ram_wren  <= 1'b0;
      r_ram_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_ram_addr <= cmd_addr;
          r_rem      <= cmd_op[1] ? cmd_len : '0;
          r_acc      <= '0;
          if (w_is_wr) begin
            r_ram_data <= cmd_data;
            r_ram_wren <= 1'b1;
            r_state    <= WR;
          end else begin
            r_state    <= RD_ADDR;
          end
        end
        WR: if (r_rem == '0) begin
          r_ram_wren  <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= '0;
          r_state     <= RESP;
        end else begin
          r_ram_addr <= r_ram_addr + ADDR_W'(1);
          r_rem      <= r_rem - ADDR_W'(1);
        end
        RD_ADDR: begin
          r_wait  <= WW'(RD_LAT - 1);
          r_state <= RD_WAIT;
        end
        RD_WAIT: if (r_wait != '0) begin
          r_wait <= r_wait - WW'(1);
        end else begin
          r_acc <= w_sum;
          if (r_rem != '0) begin
            r_ram_addr <= r_ram_addr + ADDR_W'(1);
            r_rem      <= r_rem - ADDR_W'(1);
            r_state    <= RD_ADDR;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_sum;
            r_state     <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
